// File: rtl/i2c_slave_rx.sv
// i2c_slave_rx: write-only I2C slave receiver.
//   Oversamples the open-drain bus with clk (>= 8x SCL), detects START/STOP,
//   matches a 7-bit address, ACKs the address and every data byte of a
//   write, and presents each received byte with a one-cycle strobe.
//   SCL is only sampled (no clock stretching).
//
// Ports:
//   clk      : system clock
//   reset    : synchronous, active-high reset
//   i2c_sda  : open-drain data line; driven 0 only while ACKing, else 'z
//   i2c_scl  : bus clock, sampled only
//   rx_data  : last received data byte (held until the next byte completes)
//   rx_valid : one-cycle pulse when rx_data updates
//   addr_hit : high from the address-ACK decision until the next START/STOP
//   busy     : high between a detected START and the next STOP
//
// Handshake: rx_valid is a pure strobe with no ready; the consumer must take
// rx_data in the cycle rx_valid is high (rx_data itself also stays stable).
module i2c_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR = 7'b1010101
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        i2c_sda,
  input  logic       i2c_scl,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addr_hit,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_DATA,
    S_DATA_ACK,
    S_IGNORE
  } state_t;

  state_t      state_q, state_n;
  logic [3:0]  cnt_q, cnt_n;
  logic [7:0]  shift_q, shift_n;
  logic        ack_q, ack_n;
  logic        hit_q, hit_n;
  logic        busy_q, busy_n;
  logic [7:0]  rx_data_q, rx_data_n;
  logic        rx_valid_q, rx_valid_n;

  // Two synchronizer flops plus one history flop per line; idle level is 1.
  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= i2c_scl;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= i2c_sda;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_next;

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  // Our own ACK pulls SDA; never mistake that for a bus condition.
  assign start_det = scl_s2 & sda_d & ~sda_s2 & ~ack_q;
  assign stop_det  = scl_s2 & ~sda_d & sda_s2 & ~ack_q;
  assign byte_next = {shift_q[6:0], sda_s2};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 8'h00;
      ack_q      <= 1'b0;
      hit_q      <= 1'b0;
      busy_q     <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      shift_q    <= shift_n;
      ack_q      <= ack_n;
      hit_q      <= hit_n;
      busy_q     <= busy_n;
      rx_data_q  <= rx_data_n;
      rx_valid_q <= rx_valid_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    shift_n    = shift_q;
    ack_n      = ack_q;
    hit_n      = hit_q;
    busy_n     = busy_q;
    rx_data_n  = rx_data_q;
    rx_valid_n = 1'b0;

    if (state_q != S_IDLE && start_det) begin
      // Repeated start: begin a fresh address phase.
      state_n = S_ADDR;
      cnt_n   = 4'd0;
      hit_n   = 1'b0;
      ack_n   = 1'b0;
      busy_n  = 1'b1;
    end else if (state_q != S_IDLE && stop_det) begin
      state_n = S_IDLE;
      busy_n  = 1'b0;
      hit_n   = 1'b0;
      ack_n   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_det) begin
            state_n = S_ADDR;
            cnt_n   = 4'd0;
            busy_n  = 1'b1;
          end
        end
        S_ADDR, S_DATA: begin
          if (scl_rise) begin
            shift_n = byte_next;
            cnt_n   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              if (state_q == S_ADDR) begin
                if (byte_next[7:1] == SLAVE_ADDR && !byte_next[0]) begin
                  hit_n   = 1'b1;
                  state_n = S_ADDR_ACK;
                end else begin
                  state_n = S_IGNORE;
                end
              end else begin
                rx_data_n  = byte_next;
                rx_valid_n = 1'b1;
                state_n    = S_DATA_ACK;
              end
            end
          end
        end
        S_ADDR_ACK, S_DATA_ACK: begin
          // cnt == 8: waiting for the fall that opens the ACK slot.
          // cnt == 9: ACK bit sampled by master; release on the next fall.
          if (scl_fall) begin
            if (cnt_q == 4'd9) begin
              ack_n   = 1'b0;
              cnt_n   = 4'd0;
              state_n = S_DATA;
            end else begin
              ack_n = 1'b1;
            end
          end else if (scl_rise) begin
            cnt_n = 4'd9;
          end
        end
        default: ;  // S_IGNORE: wait for START/STOP
      endcase
    end
  end

  assign i2c_sda  = ack_q ? 1'b0 : 1'bz;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign addr_hit = hit_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
module tb_i2c_slave_rx;

  localparam logic [6:0] SLAVE_ADDR = 7'b1010101;
  localparam int Q = 25;  // quarter SCL period in clk cycles (SCL = 100 clk)

  // ---------------- clock / reset / bus ----------------
  logic clk = 1'b0;
  logic reset;
  logic scl;
  logic sda_oe;
  tri1  sda;
  logic [7:0] rx_data;
  logic rx_valid, addr_hit, busy;

  assign sda = sda_oe ? 1'b0 : 1'bz;
  always #5 clk = ~clk;

  i2c_slave_rx #(.SLAVE_ADDR(SLAVE_ADDR)) dut (
    .clk      (clk),
    .reset    (reset),
    .i2c_sda  (sda),
    .i2c_scl  (scl),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .addr_hit (addr_hit),
    .busy     (busy)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_rx;
  logic prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && rx_valid) begin
      chk("rx_valid_width", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("rx_unexpected", {24'd0, rx_data}, 32'hFFFF_FFFF);
      end else begin
        chk("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
    end
    prev_valid = rx_valid;
  end

  // ---------------- driver tasks (bus master model) ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start;  // from idle bus (SCL high, SDA released)
    sda_oe = 1'b1; tick(Q);
    scl    = 1'b0; tick(Q);
  endtask

  task automatic bus_rstart;  // from SCL low
    sda_oe = 1'b0; tick(Q);
    scl    = 1'b1; tick(Q);
    sda_oe = 1'b1; tick(Q);
    scl    = 1'b0; tick(Q);
  endtask

  task automatic bus_stop;  // from SCL low
    sda_oe = 1'b1; tick(Q);
    scl    = 1'b1; tick(Q);
    sda_oe = 1'b0; tick(2 * Q);
  endtask

  task automatic write_bit(input logic b);
    sda_oe = ~b; tick(Q);
    scl    = 1'b1; tick(2 * Q);
    scl    = 1'b0; tick(Q);
  endtask

  // Returns SDA sampled mid-high and late-high during the 9th clock.
  task automatic ack_bit(output logic [1:0] s);
    sda_oe = 1'b0; tick(Q);
    scl    = 1'b1; tick(Q);
    s[1]   = sda;  tick(Q - 2);
    s[0]   = sda;  tick(2);
    scl    = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic [1:0] s);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    ack_bit(s);
  endtask

  // Full transaction; exp_ack is the expected outcome for address and data.
  task automatic do_xfer(input string name, input logic [6:0] addr, input logic rw,
                         input int nb, input logic [2:0][7:0] d, input logic exp_ack);
    logic [1:0] s;
    bus_start();
    chk({name, "_busy_start"}, {31'd0, busy}, 32'd1);
    send_byte({addr, rw}, s);
    chk({name, "_addr_ack"}, {30'd0, s}, exp_ack ? 32'd0 : 32'd3);
    chk({name, "_addr_hit"}, {31'd0, addr_hit}, {31'd0, exp_ack});
    if (!rw) begin
      for (int i = 0; i < nb; i++) begin
        if (exp_ack) begin
          exp_q.push_back(d[i]);
          last_rx = d[i];
        end
        send_byte(d[i], s);
        chk({name, "_data_ack"}, {30'd0, s}, exp_ack ? 32'd0 : 32'd3);
      end
    end
    bus_stop();
    chk({name, "_busy_stop"}, {31'd0, busy}, 32'd0);
    chk({name, "_hit_stop"}, {31'd0, addr_hit}, 32'd0);
    chk({name, "_sda_rel"}, {31'd0, sda}, 32'd1);
    chk({name, "_all_rx"}, exp_q.size(), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string           name;
    logic [6:0]      addr;
    logic            rw;
    int              nb;
    logic [2:0][7:0] d;
    logic            exp_ack;   // expected: ACK + rx_valid per byte
  } vec_t;

  vec_t vecs[4];

  logic [1:0] s;
  logic [6:0] ra;
  logic       rrw;
  int         rnb;
  logic [2:0][7:0] rd;

  initial begin
    vecs[0] = '{"wr_cc",    7'b1010101, 1'b0, 1, {8'h00, 8'h00, 8'hCC}, 1'b1};
    vecs[1] = '{"mismatch", 7'b0101010, 1'b0, 1, {8'h00, 8'h00, 8'h33}, 1'b0};
    vecs[2] = '{"read",     7'b1010101, 1'b1, 0, {8'h00, 8'h00, 8'h00}, 1'b0};
    vecs[3] = '{"wr_two",   7'b1010101, 1'b0, 2, {8'h00, 8'h22, 8'h11}, 1'b1};

    reset = 1'b1; scl = 1'b1; sda_oe = 1'b0; last_rx = 8'h00;
    tick(5);
    chk("rst_rx_data",  {24'd0, rx_data}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_addr_hit", {31'd0, addr_hit}, 32'd0);
    chk("rst_busy",     {31'd0, busy}, 32'd0);
    chk("rst_sda",      {31'd0, sda}, 32'd1);
    reset = 1'b0;
    tick(10);

    for (int i = 0; i < 4; i++)
      do_xfer(vecs[i].name, vecs[i].addr, vecs[i].rw, vecs[i].nb, vecs[i].d, vecs[i].exp_ack);

    // Multi-byte write with repeated start.
    bus_start();
    send_byte({SLAVE_ADDR, 1'b0}, s);
    chk("ms_addr_ack", {30'd0, s}, 32'd0);
    exp_q.push_back(8'hA5); send_byte(8'hA5, s);
    chk("ms_a5_ack", {30'd0, s}, 32'd0);
    exp_q.push_back(8'h3C); send_byte(8'h3C, s);
    chk("ms_3c_ack", {30'd0, s}, 32'd0);
    bus_rstart();
    chk("rs_hit_drop", {31'd0, addr_hit}, 32'd0);
    chk("rs_busy", {31'd0, busy}, 32'd1);
    send_byte({SLAVE_ADDR, 1'b0}, s);
    chk("rs_addr_ack", {30'd0, s}, 32'd0);
    chk("rs_hit", {31'd0, addr_hit}, 32'd1);
    exp_q.push_back(8'h7E); send_byte(8'h7E, s);
    chk("rs_7e_ack", {30'd0, s}, 32'd0);
    last_rx = 8'h7E;
    bus_stop();
    chk("ms_busy_stop", {31'd0, busy}, 32'd0);
    chk("ms_all_rx", exp_q.size(), 32'd0);

    // Abort after 5 data bits.
    bus_start();
    send_byte({SLAVE_ADDR, 1'b0}, s);
    chk("ab_addr_ack", {30'd0, s}, 32'd0);
    for (int i = 0; i < 5; i++) write_bit(i[0]);
    bus_stop();
    chk("ab_rx_data", {24'd0, rx_data}, {24'd0, last_rx});
    chk("ab_busy", {31'd0, busy}, 32'd0);
    chk("ab_hit", {31'd0, addr_hit}, 32'd0);
    chk("ab_sda", {31'd0, sda}, 32'd1);

    // Reset while the slave holds the address ACK.
    bus_start();
    for (int i = 7; i >= 1; i--) write_bit(SLAVE_ADDR[i-1]);
    write_bit(1'b0);
    sda_oe = 1'b0; tick(Q);
    scl = 1'b1; tick(Q);
    chk("ra_sda_held", {31'd0, sda}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("ra_sda_rel", {31'd0, sda}, 32'd1);
    @(negedge clk);
    chk("ra_rx_data", {24'd0, rx_data}, 32'd0);
    chk("ra_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("ra_hit", {31'd0, addr_hit}, 32'd0);
    chk("ra_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0; last_rx = 8'h00;
    tick(Q); scl = 1'b0; tick(Q);
    bus_stop();
    chk("ra_idle_busy", {31'd0, busy}, 32'd0);
    do_xfer("after_rst", SLAVE_ADDR, 1'b0, 1, {8'h00, 8'h00, 8'h5A}, 1'b1);

    // Randomized transactions against the reference rule:
    // bytes are accepted (ACKed and strobed) iff address matches and it is a write.
    for (int t = 0; t < 8; t++) begin
      ra  = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(0, 127)) : SLAVE_ADDR;
      rrw = ($urandom_range(0, 3) == 0);
      rnb = $urandom_range(1, 3);
      rd  = 24'($urandom);
      do_xfer("rand", ra, rrw, rnb, rd, (ra == SLAVE_ADDR) && !rrw);
    end

    tick(200);
    chk("exp_q_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave_rx.md
Name: i2c_slave_rx

Overview:
- Write-only I2C slave receiver on the same open-drain `i2c_sda`/`i2c_scl` bus driven by `i2c_master`. It is the downstream consumer of master write transactions.
- Oversamples the bus with `clk`, detects START/STOP, and matches a 7-bit address.
- On a write with matching address: ACKs the address and every data byte, and presents each received byte on a one-cycle valid strobe.
- Never drives SCL (no clock stretching).

Parameters:
- `SLAVE_ADDR`, 7'b1010101, 7-bit address this slave responds to.

Ports:
- `clk`  input  1  system clock; the bus is oversampled ≥8x SCL rate.
- `reset`  input  1  synchronous, active-high reset.
- `i2c_sda`  inout  1  open-drain data line. Driven 1'b0 only when ACKing, otherwise 1'bz.
- `i2c_scl`  input  1  bus clock; sampled only, never driven.
- `rx_data`  output  8  last received data byte, MSB first on the wire. Holds its value until the next byte completes.
- `rx_valid`  output  1  one-cycle pulse when `rx_data` is updated.
- `addr_hit`  output  1  high from the address-ACK decision until the next STOP or START.
- `busy`  output  1  high between a detected START and the next STOP.

Behaviour:
- **Input sampling:** SCL and SDA pass through 2-flop synchronizers, plus one history flop each. All events use the synchronized values.
  - `scl_rise`, `scl_fall`: edges of synchronized SCL.
  - START: synchronized SDA 1→0 while synchronized SCL = 1.
  - STOP: synchronized SDA 0→1 while synchronized SCL = 1.
  - Pad-to-event latency is 3 `clk` cycles.
- **Bit sampling:** data bits are sampled on `scl_rise`, shifted MSB first into an 8-bit register, and counted by a 4-bit counter.
- **State machine:** IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
  - IDLE: on START → ADDR, bit count cleared, `busy` = 1.
  - ADDR: after the 8th `scl_rise`:
    - If byte[7:1] == `SLAVE_ADDR` and byte[0] == 0 (write): set `addr_hit` = 1, → ADDR_ACK.
    - Otherwise (wrong address or read): → IGNORE, SDA never driven.
  - ADDR_ACK: on the first `scl_fall`, drive SDA low. Hold through the 9th `scl_rise`. On the following `scl_fall`, release SDA → DATA, count cleared.
  - DATA: after the 8th `scl_rise`, `rx_data` <= shift value and `rx_valid` = 1 on the next `clk` cycle (single cycle) → DATA_ACK.
  - DATA_ACK: same drive/release timing as ADDR_ACK → DATA. This supports multi-byte writes.
  - IGNORE: wait; SDA released.
- **START/STOP in any non-IDLE state (highest priority):**
  - START (repeated start) → ADDR: count cleared, `addr_hit` = 0, SDA released.
  - STOP → IDLE: `busy` = 0, `addr_hit` = 0, SDA released.
- **Partial byte:** a STOP or START before the 8th bit discards the partial byte. No `rx_valid`; `rx_data` is unchanged.
- **ACK-time events:** START/STOP detection is suppressed while this slave itself drives SDA low. A master-generated STOP during ACK therefore cannot occur per protocol.
- **Reset (synchronous):**
  - Values: state = IDLE; `rx_data` = 8'h00; `rx_valid` = 0; `addr_hit` = 0; `busy` = 0; SDA released (1'bz); synchronizer flops = 1 (idle bus level).
  - Reset mid-transfer releases SDA in the cycle after the reset edge. The slave resumes only on a fresh START.
- **Wire-level rule:** `i2c_sda` = (ack_drive ? 1'b0 : 1'bz). No other driver exists inside the block.

Test Plan:
- **Single-byte write:** bus model with pullups (tri1), SCL period 100 clk. Send START, addr 1010101+W, data 8'hCC, STOP.
  - Required: SDA = 0 during both 9th-bit SCL highs.
  - Required: `rx_valid` pulses exactly once with `rx_data` = 8'hCC.
  - Required: `busy` 1→0 at STOP; `addr_hit` = 0 after STOP.
- **Address mismatch:** send addr 0101010+W, data 8'h33.
  - Required: SDA never driven low, so SDA reads 1 at both ACK bits.
  - Required: no `rx_valid`; `addr_hit` stays 0; `busy` pulses START→STOP.
- **Read request:** send addr 1010101+R.
  - Required: NACK (SDA = 1 at ACK bit); state enters IGNORE; no `rx_valid`.
- **Multi-byte write plus repeated start:** send bytes 8'hA5, 8'h3C, then repeated START with addr 1010101+W, 8'h7E, STOP.
  - Required: three `rx_valid` pulses carrying 8'hA5, 8'h3C, 8'h7E, in that order.
  - Required: `addr_hit` drops for at least 1 cycle at the repeated START.
- **Abort mid-byte:** send STOP after 5 data bits.
  - Required: no `rx_valid`; `rx_data` keeps its previous value; state IDLE; SDA released.
- **Reset during address ACK:** assert `reset` while the slave holds SDA low.
  - Required: SDA released the cycle after the reset edge; all outputs at reset values.
  - Required: next full write transaction with 8'h5A is received correctly.
